// File: rtl/nac_dma_pkg.sv
// rtl/nac_dma_pkg.sv - shared types and constants for the NAC DMA burst engine
//
// Purpose: FSM state encoding and address/response constants used by the
//          burst engine and its burst-length calculator.
// Contents:
//   state_t      - burst engine FSM states
//   AXI_4K_BYTES - size of the region a single burst may not cross
//   WORD_BYTES   - bytes per transferred word
//   RESP_OKAY    - AXI OKAY response code
package nac_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_REQ   = 3'd2,
    ST_RDATA = 3'd3,
    ST_WDATA = 3'd4,
    ST_WRESP = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  localparam int AXI_4K_BYTES = 4096;
  localparam int WORD_BYTES   = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/nac_burst_len_calc.sv
// rtl/nac_burst_len_calc.sv - combinational burst length selection
//
// Purpose: picks the length of the next INCR burst as the smallest of the
//          remaining word count, MAX_BURST and the words left before the
//          next 4 KB boundary.
// Ports:
//   addr_lo   in  10      word index within the current 4 KB page (addr[11:2])
//   remaining in  CNT_W   words still to transfer
//   len       out 9       burst length in beats, 1..MAX_BURST
module nac_burst_len_calc
  import nac_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic [9:0]       addr_lo,
  input  logic [CNT_W-1:0] remaining,
  output logic [8:0]       len
);

  localparam logic [10:0] BEATS_PER_4K = 11'(AXI_4K_BYTES / WORD_BYTES);
  localparam logic [10:0] MAX_BEATS    = 11'(MAX_BURST);

  logic [10:0] beats_to_4k;
  logic [10:0] cap;

  always_comb begin
    // 1024 - word index never underflows and yields 1..1024.
    beats_to_4k = BEATS_PER_4K - {1'b0, addr_lo};
    cap         = (MAX_BEATS < beats_to_4k) ? MAX_BEATS : beats_to_4k;
    // cap never exceeds 256, so the final value always fits 9 bits.
    if (remaining < CNT_W'(cap)) begin
      len = 9'(remaining);
    end else begin
      len = 9'(cap);
    end
  end

endmodule

// File: rtl/nac_dma_burst_engine.sv
// rtl/nac_dma_burst_engine.sv - DMA command front end splitting transfers into bursts
//
// Purpose: accepts one transfer command of up to 2^CNT_W-1 words, splits it
//          into INCR bursts that respect MAX_BURST and 4 KB boundaries, and
//          drives the NAC AXI master adapter sys_* interface.
// Ports:
//   ACLK, ARESET                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_we, cmd_addr, cmd_words      command direction, byte address, word count
//   busy, done, done_err             status; done is a one-cycle pulse
//   rd_data, rd_valid                read word stream (no backpressure)
//   wr_data, wr_valid, wr_ready      write source stream
//   sys_addr, sys_len, sys_req, sys_we          adapter burst request
//   sys_wdata, sys_wvalid, sys_wready           adapter write data handshake
//   sys_grant, sys_valid, sys_last, sys_rdata   adapter completion / read beats
//   sys_error                                   adapter sticky burst error
module nac_dma_burst_engine
  import nac_dma_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [CNT_W-1:0] cmd_words,
  output logic             busy,
  output logic             done,
  output logic             done_err,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      sys_addr,
  output logic [7:0]       sys_len,
  output logic             sys_req,
  output logic             sys_we,
  output logic [31:0]      sys_wdata,
  output logic             sys_wvalid,
  input  logic             sys_wready,
  input  logic             sys_grant,
  input  logic             sys_valid,
  input  logic             sys_last,
  input  logic [31:0]      sys_rdata,
  input  logic             sys_error
);

  state_t           state;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] remaining;
  logic [8:0]       len_q;
  logic [8:0]       wcnt;
  logic             we_q;
  logic             err_q;
  logic [8:0]       calc_len;

  logic [31:0]      next_addr;
  logic             last_burst;
  logic             in_wdata;
  logic             wr_xfer;

  nac_burst_len_calc #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_len_calc (
    .addr_lo   (addr_q[11:2]),
    .remaining (remaining),
    .len       (calc_len)
  );

  // Write data passes straight through while the burst data phase is open;
  // outside WDATA neither side sees a handshake.
  assign in_wdata   = (state == ST_WDATA);
  assign sys_wdata  = wr_data;
  assign sys_wvalid = in_wdata & wr_valid;
  assign wr_ready   = in_wdata & sys_wready;
  assign wr_xfer    = wr_valid & sys_wready;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  // Address advance wraps naturally at 2^32.
  assign next_addr  = addr_q + {21'd0, len_q, 2'b00};
  assign last_burst = (remaining == CNT_W'(len_q));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      remaining <= '0;
      len_q     <= '0;
      wcnt      <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      sys_addr  <= '0;
      sys_len   <= '0;
      sys_req   <= 1'b0;
      sys_we    <= 1'b0;
    end else begin
      sys_req  <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
      rd_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr & 32'hFFFF_FFFC;
            remaining <= cmd_words;
            we_q      <= cmd_we;
            err_q     <= 1'b0;
            state     <= (cmd_words == '0) ? ST_FIN : ST_CALC;
          end
        end

        ST_CALC: begin
          len_q    <= calc_len;
          sys_len  <= 8'(calc_len - 9'd1);
          sys_addr <= addr_q;
          sys_we   <= we_q;
          sys_req  <= 1'b1;
          wcnt     <= '0;
          state    <= ST_REQ;
        end

        ST_REQ: begin
          state <= we_q ? ST_WDATA : ST_RDATA;
        end

        ST_RDATA: begin
          rd_data  <= sys_rdata;
          rd_valid <= sys_valid;
          if (sys_valid && sys_last) begin
            err_q     <= err_q | sys_error;
            addr_q    <= next_addr;
            remaining <= remaining - CNT_W'(len_q);
            state     <= last_burst ? ST_FIN : ST_CALC;
          end
        end

        ST_WDATA: begin
          if (wr_xfer) begin
            wcnt <= wcnt + 9'd1;
            if ((wcnt + 9'd1) == len_q) begin
              state <= ST_WRESP;
            end
          end
        end

        ST_WRESP: begin
          if (sys_grant) begin
            err_q     <= err_q | sys_error;
            addr_q    <= next_addr;
            remaining <= remaining - CNT_W'(len_q);
            state     <= last_burst ? ST_FIN : ST_CALC;
          end
        end

        ST_FIN: begin
          done     <= 1'b1;
          done_err <= err_q;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
